// File: rtl/serial_read_ctrl.sv
// Sequences the external negedge-capturing shift register: clears it, issues WORD_BITS
// shift falling edges at CLK_DIV clk cycles per half-period, then latches and offers the word.
module serial_read_ctrl #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned WORD_BITS = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 shift,
  output logic                 sr_clear_n,
  input  logic [WORD_BITS-1:0] sr_word,
  output logic [WORD_BITS-1:0] word_out,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic                 overrun
);

  localparam int unsigned CNT_W = $clog2(WORD_BITS) + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_HIGH  = 3'd2;
  localparam logic [2:0] S_LOW   = 3'd3;
  localparam logic [2:0] S_LOAD  = 3'd4;

  localparam logic [7:0]       PHASE_LAST = 8'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BITS_ALL   = CNT_W'(WORD_BITS);

  logic [2:0]       state;
  logic [7:0]       phase_cnt;
  logic [CNT_W-1:0] bit_cnt;

  // NOTE: every register here uses <= so all updates in one edge see the pre-edge values;
  // later assignments in the same edge intentionally override earlier defaults.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      phase_cnt  <= '0;
      bit_cnt    <= '0;
      shift      <= 1'b1;
      sr_clear_n <= 1'b0;
      busy       <= 1'b0;
      word_out   <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (word_valid && word_ready) word_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          shift      <= 1'b1;
          sr_clear_n <= 1'b1;
          busy       <= 1'b0;
          if (start) begin
            state      <= S_CLEAR;
            sr_clear_n <= 1'b0;
          end
        end

        S_CLEAR: begin
          sr_clear_n <= 1'b1;
          busy       <= 1'b1;
          phase_cnt  <= '0;
          state      <= S_HIGH;
        end

        S_HIGH: begin
          if (phase_cnt == PHASE_LAST) begin
            phase_cnt <= '0;
            if (bit_cnt < BITS_ALL) begin
              state   <= S_LOW;
              shift   <= 1'b0;
              bit_cnt <= bit_cnt + 1'b1;
            end else begin
              // Trailing high phase is over: the captured word has settled.
              state <= S_LOAD;
            end
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        S_LOW: begin
          if (phase_cnt == PHASE_LAST) begin
            phase_cnt <= '0;
            state     <= S_HIGH;
            shift     <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        S_LOAD: begin
          word_out   <= sr_word;
          word_valid <= 1'b1;
          overrun    <= word_valid && !word_ready;
          bit_cnt    <= '0;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_read_ctrl.sv
// Directed bench for serial_read_ctrl with behavioural models of the negedge shift register;
// a CLK_DIV=4 instance covers the main scenarios and a CLK_DIV=1 instance back-to-back.
module tb_serial_read_ctrl;

  logic clk = 1'b0;
  logic reset_n;

  // CLK_DIV = 4 instance
  logic        start, busy, shift, sr_clear_n, word_valid, word_ready, overrun;
  logic [31:0] sr_word, word_out;
  logic [31:0] stream = '0;
  logic [31:0] sr_q   = '0;
  int          bit_idx  = 0;
  int          fall_cnt = 0;

  // CLK_DIV = 1 instance
  logic        start1, busy1, shift1, sr_clear_n1, word_valid1, word_ready1, overrun1;
  logic [31:0] sr_word1, word_out1;
  logic [31:0] stream1 = 32'h0000_0001;
  logic [31:0] sr_q1   = '0;
  int          bit_idx1  = 0;
  int          fall_cnt1 = 0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_read_ctrl #(.CLK_DIV(4), .WORD_BITS(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .shift(shift),
    .sr_clear_n(sr_clear_n), .sr_word(sr_word), .word_out(word_out),
    .word_valid(word_valid), .word_ready(word_ready), .overrun(overrun)
  );

  serial_read_ctrl #(.CLK_DIV(1), .WORD_BITS(32)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .busy(busy1), .shift(shift1),
    .sr_clear_n(sr_clear_n1), .sr_word(sr_word1), .word_out(word_out1),
    .word_valid(word_valid1), .word_ready(word_ready1), .overrun(overrun1)
  );

  // Shift register models: MSB of the stream first, one bit per falling edge of shift.
  always @(negedge shift or negedge sr_clear_n) begin
    if (!sr_clear_n) begin
      sr_q    <= '0;
      bit_idx <= 0;
    end else begin
      sr_q    <= {sr_q[30:0], stream[5'(31 - bit_idx)]};
      bit_idx <= bit_idx + 1;
    end
  end
  assign sr_word = sr_q;

  always @(negedge shift1 or negedge sr_clear_n1) begin
    if (!sr_clear_n1) begin
      sr_q1    <= '0;
      bit_idx1 <= 0;
    end else begin
      sr_q1    <= {sr_q1[30:0], stream1[5'(31 - bit_idx1)]};
      bit_idx1 <= bit_idx1 + 1;
    end
  end
  assign sr_word1 = sr_q1;

  always @(negedge shift)  fall_cnt  <= fall_cnt + 1;
  always @(negedge shift1) fall_cnt1 <= fall_cnt1 + 1;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Applies start for exactly one rising edge (edge 0 of the transaction).
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Returns the edge index (from edge 0) at which word_valid is first seen, or -1.
  task automatic wait_valid(input int max_cycles, output int lat);
    lat = -1;
    for (int n = 1; n <= max_cycles; n++) begin
      tick();
      if (word_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    tests++; if (shift !== 1'b1) begin fails++; $display("FAIL reset_shift: got %b want 1", shift); end
    tests++; if (sr_clear_n !== 1'b0) begin fails++; $display("FAIL reset_sr_clear_n: got %b want 0", sr_clear_n); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (word_valid !== 1'b0) begin fails++; $display("FAIL reset_word_valid: got %b want 0", word_valid); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    tests++; if (word_out !== 32'h0) begin fails++; $display("FAIL reset_word_out: got %h want 00000000", word_out); end
    reset_n = 1'b1;
    tick();
    tests++; if (sr_clear_n !== 1'b1) begin fails++; $display("FAIL release_sr_clear_n: got %b want 1", sr_clear_n); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL release_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    int lat;
    int f0;
    stream     = 32'hA5C3_0F96;
    word_ready = 1'b1;
    f0         = fall_cnt;
    lat        = -1;
    pulse_start();
    tests++; if (sr_clear_n !== 1'b0) begin fails++; $display("FAIL single_clear_low: got %b want 0", sr_clear_n); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_edge0: got %b want 0", busy); end
    for (int n = 1; n <= 300; n++) begin
      tick();
      if (n == 1) begin
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy_edge1: got %b want 1", busy); end
        tests++; if (sr_clear_n !== 1'b1) begin fails++; $display("FAIL single_clear_release: got %b want 1", sr_clear_n); end
      end
      if (n == 4) begin
        tests++; if (shift !== 1'b1) begin fails++; $display("FAIL single_shift_e4: got %b want 1", shift); end
      end
      if (n == 5 || n == 8) begin
        tests++; if (shift !== 1'b0) begin fails++; $display("FAIL single_shift_e%0d: got %b want 0", n, shift); end
      end
      if (n == 9) begin
        tests++; if (shift !== 1'b1) begin fails++; $display("FAIL single_shift_e9: got %b want 1", shift); end
      end
      if (word_valid) begin
        lat = n;
        break;
      end
    end
    tests++; if (lat != 262) begin fails++; $display("FAIL single_latency: got %0d want 262", lat); end
    tests++; if (word_out !== 32'hA5C3_0F96) begin fails++; $display("FAIL single_word: got %h want a5c30f96", word_out); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_done: got %b want 0", busy); end
    tests++; if (fall_cnt - f0 != 32) begin fails++; $display("FAIL single_falls: got %0d want 32", fall_cnt - f0); end
    tests++; if (shift !== 1'b1) begin fails++; $display("FAIL single_shift_idle: got %b want 1", shift); end
    tick();
    tests++; if (word_valid !== 1'b0) begin fails++; $display("FAIL single_valid_one_cycle: got %b want 0", word_valid); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL single_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_backpressure();
    int lat;
    int held;
    stream     = 32'hA5C3_0F96;
    word_ready = 1'b0;
    pulse_start();
    wait_valid(300, lat);
    tests++; if (lat != 262) begin fails++; $display("FAIL bp_latency: got %0d want 262", lat); end
    held = (lat > 0) ? 1 : 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (word_valid) held++;
    end
    tests++; if (held != 10) begin fails++; $display("FAIL bp_held: got %0d want 10", held); end
    word_ready = 1'b1;
    tick();
    tests++; if (word_valid !== 1'b0) begin fails++; $display("FAIL bp_cleared: got %b want 0", word_valid); end
    tests++; if (word_out !== 32'hA5C3_0F96) begin fails++; $display("FAIL bp_word_hold: got %h want a5c30f96", word_out); end
    tick();
    tests++; if (word_valid !== 1'b0) begin fails++; $display("FAIL bp_ready_idle: got %b want 0", word_valid); end
  endtask

  task automatic test_overrun();
    int lat;
    int ov_cnt;
    stream     = 32'h1234_5678;
    word_ready = 1'b0;
    pulse_start();
    wait_valid(300, lat);
    tests++; if (word_out !== 32'h1234_5678) begin fails++; $display("FAIL ovr_first_word: got %h want 12345678", word_out); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_first_no_overrun: got %b want 0", overrun); end
    tick();
    stream = 32'hDEAD_BEEF;
    ov_cnt = 0;
    pulse_start();
    for (int n = 1; n <= 262; n++) begin
      tick();
      if (overrun) ov_cnt++;
    end
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_pulse_at_load: got %b want 1", overrun); end
    tests++; if (ov_cnt != 1) begin fails++; $display("FAIL ovr_pulse_count: got %0d want 1", ov_cnt); end
    tests++; if (word_out !== 32'hDEAD_BEEF) begin fails++; $display("FAIL ovr_second_word: got %h want deadbeef", word_out); end
    tick();
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_one_cycle: got %b want 0", overrun); end
    tests++; if (word_valid !== 1'b1) begin fails++; $display("FAIL ovr_valid_held: got %b want 1", word_valid); end
    word_ready = 1'b1;
    tick();
    tests++; if (word_valid !== 1'b0) begin fails++; $display("FAIL ovr_accept: got %b want 0", word_valid); end
  endtask

  task automatic test_start_busy();
    int f0;
    int valid_cnt;
    stream     = 32'h3C3C_5AA5;
    word_ready = 1'b1;
    f0         = fall_cnt;
    valid_cnt  = 0;
    pulse_start();
    for (int n = 1; n <= 420; n++) begin
      start = (n == 50 || n == 100);
      tick();
      start = 1'b0;
      if (n == 50) begin
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL sb_busy_mid: got %b want 1", busy); end
      end
      if (word_valid) valid_cnt++;
    end
    tests++; if (valid_cnt != 1) begin fails++; $display("FAIL sb_word_count: got %0d want 1", valid_cnt); end
    tests++; if (fall_cnt - f0 != 32) begin fails++; $display("FAIL sb_falls: got %0d want 32", fall_cnt - f0); end
    tests++; if (word_out !== 32'h3C3C_5AA5) begin fails++; $display("FAIL sb_word: got %h want 3c3c5aa5", word_out); end
  endtask

  task automatic test_reset_abort();
    int f0;
    int valid_cnt;
    int lat;
    stream     = 32'hFFFF_FFFF;
    word_ready = 1'b1;
    f0         = fall_cnt;
    pulse_start();
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (fall_cnt - f0 == 10) break;
    end
    tests++; if (fall_cnt - f0 != 10) begin fails++; $display("FAIL abort_reach_10: got %0d want 10", fall_cnt - f0); end
    reset_n = 1'b0;
    tick();
    tests++; if (shift !== 1'b1) begin fails++; $display("FAIL abort_shift: got %b want 1", shift); end
    tests++; if (sr_clear_n !== 1'b0) begin fails++; $display("FAIL abort_sr_clear_n: got %b want 0", sr_clear_n); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b want 0", busy); end
    tests++; if (sr_word !== 32'h0) begin fails++; $display("FAIL abort_sr_cleared: got %h want 00000000", sr_word); end
    reset_n = 1'b1;
    valid_cnt = 0;
    for (int n = 0; n < 300; n++) begin
      tick();
      if (word_valid) valid_cnt++;
    end
    tests++; if (valid_cnt != 0) begin fails++; $display("FAIL abort_no_partial: got %0d want 0", valid_cnt); end
    tests++; if (fall_cnt - f0 != 10) begin fails++; $display("FAIL abort_no_extra_fall: got %0d want 10", fall_cnt - f0); end
    f0 = fall_cnt;
    pulse_start();
    wait_valid(300, lat);
    tests++; if (lat != 262) begin fails++; $display("FAIL abort_next_latency: got %0d want 262", lat); end
    tests++; if (word_out !== 32'hFFFF_FFFF) begin fails++; $display("FAIL abort_next_word: got %h want ffffffff", word_out); end
    tests++; if (fall_cnt - f0 != 32) begin fails++; $display("FAIL abort_next_falls: got %0d want 32", fall_cnt - f0); end
  endtask

  task automatic test_back_to_back();
    int v_edge[3];
    int k;
    int f0;
    k           = 0;
    word_ready1 = 1'b1;
    f0          = fall_cnt1;
    start1      = 1'b1;
    tick();
    for (int n = 1; n <= 220; n++) begin
      tick();
      if (n <= 4) begin
        tests++;
        if (shift1 !== ((n % 2) == 1)) begin
          fails++; $display("FAIL b2b_toggle_e%0d: got %b want %b", n, shift1, (n % 2) == 1);
        end
      end
      if (word_valid1 && k < 3) begin
        v_edge[k] = n;
        tests++; if (word_out1 !== 32'h0000_0001) begin fails++; $display("FAIL b2b_word%0d: got %h want 00000001", k, word_out1); end
        tests++; if (fall_cnt1 - f0 != 32 * (k + 1)) begin fails++; $display("FAIL b2b_falls%0d: got %0d want %0d", k, fall_cnt1 - f0, 32 * (k + 1)); end
        k++;
      end
    end
    tests++; if (k != 3) begin fails++; $display("FAIL b2b_word_count: got %0d want 3", k); end
    if (k == 3) begin
      tests++; if (v_edge[0] != 67) begin fails++; $display("FAIL b2b_latency: got %0d want 67", v_edge[0]); end
      tests++; if (v_edge[1] - v_edge[0] != 68) begin fails++; $display("FAIL b2b_period1: got %0d want 68", v_edge[1] - v_edge[0]); end
      tests++; if (v_edge[2] - v_edge[1] != 68) begin fails++; $display("FAIL b2b_period2: got %0d want 68", v_edge[2] - v_edge[1]); end
    end
    start1 = 1'b0;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (!busy1) break;
    end
    tests++; if (busy1 !== 1'b0) begin fails++; $display("FAIL b2b_stop: got %b want 0", busy1); end
  endtask

  initial begin
    reset_n     = 1'b0;
    start       = 1'b0;
    word_ready  = 1'b0;
    start1      = 1'b0;
    word_ready1 = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_backpressure();
    test_overrun();
    test_start_busy();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
